udp_pkt_gen: RTL
================

Name: udp_pkt_gen

Overview:
Parametrised periodic UDP packet source that feeds the IP framing block. It emits an 8-byte UDP header followed by a generated payload as one byte per clk on the start/data interface that the IP block consumes. Generalises the fixed single-string UDP test source: it has configurable ports, payload length and period, four payload modes, a packet counter and busy-aware launch. Sits between application/test logic and the IP block; the IP block drives the RTL8201 MII MAC.

Parameters:
SRC_PORT, 16'h1388, UDP source port.
DST_PORT, 16'h1770, UDP destination port.
PAYLOAD_LEN, 22, payload bytes; legal range 1..1472.
PERIOD, 10_000_000, idle clk cycles between end of one packet and launch of the next; minimum 1.
SRC_IP, 32'hc0a80002, source IP for the checksum pseudo-header (used only with UDP_CSUM_EN).
DST_IP, 32'hc0a80003, destination IP for the checksum pseudo-header (used only with UDP_CSUM_EN).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
enable  in  1  allow periodic launches.
mode  in  2  payload mode; sampled at launch.
seed  in  8  payload seed; sampled at launch.
busy  in  1  IP block busy; no launch while high.
start  out  1  frame-active strobe to the IP block.
data  out  8  header/payload byte to the IP block.
udp_len  out  16  PAYLOAD_LEN+8; constant, routed to the IP block len input.
pkt_cnt  out  32  packets completed; wraps at 2^32.
done  out  1  one-cycle pulse when a packet ends.

Behaviour:
- Reset values: start=0, data=0, pkt_cnt=0, done=0, FSM=IDLE, period counter=0. Reset wins over any in-flight packet; start is 0 after the resetting edge.
- IDLE: if enable=0, hold the counter at 0. Otherwise increment the counter. On counter==PERIOD-1, clear the counter and go to WAIT.
- WAIT: stay while busy=1. When busy=0, latch mode and seed, and go to CSUM if compiled in, else LAUNCH.
- LAUNCH (1 cycle): start<=1; data holds its previous value.
- HDR (8 cycles): data = SRC_PORT[15:8], SRC_PORT[7:0], DST_PORT[15:8], DST_PORT[7:0], udp_len[15:8], udp_len[7:0], csum[15:8], csum[7:0].
- PAY (PAYLOAD_LEN cycles): data = payload byte i, for i = 0..PAYLOAD_LEN-1.
- END (1 cycle): start<=0, done<=1, pkt_cnt<=pkt_cnt+1, then go to IDLE.
- start is high for exactly PAYLOAD_LEN+9 cycles. Byte k (k=0..PAYLOAD_LEN+7) is valid in the (k+2)th cycle of start-high. The last byte stays valid in the cycle where start falls.
- Payload modes, all arithmetic mod 256:
  - 0 constant: every byte = seed.
  - 1 increment: byte i = seed+i.
  - 2 LFSR: byte 0 = seed, or 8'h01 if seed==0. Each next byte is a Galois LFSR step with polynomial x^8+x^6+x^5+x^4+1.
  - 3 sequence: bytes 0..3 = pkt_cnt big-endian, latched at launch; byte i≥4 = seed+i. If PAYLOAD_LEN<4, truncate to the first PAYLOAD_LEN bytes of pkt_cnt.
- enable falling mid-packet does not abort; the packet completes, then the block stays in IDLE.
- busy is ignored after WAIT. Changes to mode/seed mid-packet have no effect.
- done and the pkt_cnt increment fire in the same cycle.

Optional Feature:
- Macro UDP_CSUM_EN.
- Defined:
  - Adds state CSUM between WAIT and LAUNCH, lasting PAYLOAD_LEN+1 cycles.
  - In CSUM, the payload generator runs silently with start=0 and data held.
  - A 32-bit accumulator sums the pseudo-header (SRC_IP, DST_IP, 16'h0011, udp_len), the UDP header with csum=0, and the payload as big-endian 16-bit words. An odd final byte is padded with a 00 low byte.
  - The carries are folded, then the result is one's-complemented. A result of 16'h0000 is transmitted as 16'hFFFF.
  - The generator then restarts from the latched seed so PAY reproduces identical bytes.
- Undefined: the csum field is 16'h0000 (checksum disabled) and the CSUM state does not exist.

Test Plan:
- Defaults, PERIOD=20, mode=1, seed=8'h48, busy=0, enable=1 after reset -> start high 31 cycles; data = 13 88 17 70 00 1E 00 00 48 49 … 5D; done pulses once; pkt_cnt=1; next launch 20 cycles after END.
- busy held high for 50 cycles at launch time -> start stays 0 until busy falls; LAUNCH occurs 1 cycle after busy=0.
- mode=2, seed=0, PAYLOAD_LEN=4 -> payload 01 B8 5C 2E (Galois LFSR, taps 8'hB8); mode=0, seed=8'hA5 -> A5 A5 A5 A5.
- mode=3, seed=0, three consecutive packets -> payload bytes 0..3 = 00000000, 00000001, 00000002; byte 4 = 8'h04.
- rst asserted in the 10th cycle of PAY -> start=0, pkt_cnt=0, no done pulse; after release the next packet appears only after PERIOD cycles.
- UDP_CSUM_EN, defaults, mode=1, seed=8'h48 -> csum bytes equal a software-computed RFC 768 checksum; start rises PAYLOAD_LEN+1 cycles later than without the macro; enable dropped mid-packet -> that packet completes and no further start.

Source files
------------

// File: rtl/udp_pkt_gen.sv
// udp_pkt_gen: periodic UDP packet source for the IP framing block.
// Emits an 8-byte UDP header followed by a generated payload, one byte per
// clk, framed by the start strobe. Payload modes: constant, increment,
// Galois LFSR (taps 8'hB8) and packet-counter sequence.
// Optional build macro UDP_CSUM_EN: adds a pre-pass state that computes the
// RFC 768 checksum before launch; without it the csum field is 16'h0000.
// Handshake: there is no ready; a packet launches only from WAIT while busy
// is low, and once launched it runs to completion regardless of busy/enable.
module udp_pkt_gen #(
    parameter logic [15:0] SRC_PORT    = 16'h1388,
    parameter logic [15:0] DST_PORT    = 16'h1770,
    parameter int          PAYLOAD_LEN = 22,
    parameter int          PERIOD      = 10_000_000,
    parameter logic [31:0] SRC_IP      = 32'hc0a80002,
    parameter logic [31:0] DST_IP      = 32'hc0a80003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  seed,
    input  logic        busy,
    output logic        start,
    output logic [7:0]  data,
    output logic [15:0] udp_len,
    output logic [31:0] pkt_cnt,
    output logic        done
);

    localparam logic [15:0] LEN16    = 16'(PAYLOAD_LEN + 8);
    localparam logic [10:0] PAY_LAST = 11'(PAYLOAD_LEN - 1);
    localparam logic [31:0] PER_LAST = 32'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAUNCH,
        S_HDR,
        S_PAY,
        S_END
`ifdef UDP_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t      state;
    logic [31:0] per_cnt;
    logic [10:0] idx;       // header byte index in HDR, payload index in PAY/CSUM
    logic [1:0]  mode_q;
    logic [7:0]  seed_q;
    logic [31:0] cnt_q;     // pkt_cnt snapshot for sequence mode
    logic [7:0]  gen_q;     // generator value for the current payload index
    logic [7:0]  cur_byte;
    logic [15:0] csum_field;

    assign udp_len = LEN16;

    // First payload byte for a mode/seed pair (LFSR must never start at 0).
    function automatic logic [7:0] first_byte(input logic [1:0] m, input logic [7:0] s);
        logic [7:0] r;
        r = s;
        if (m == 2'd2 && s == 8'h00) r = 8'h01;
        return r;
    endfunction

    // Advance the generator by one payload byte.
    function automatic logic [7:0] next_gen(input logic [1:0] m, input logic [7:0] g);
        logic [7:0] r;
        case (m)
            2'd0:    r = g;
            2'd2:    r = {1'b0, g[7:1]} ^ (g[0] ? 8'hB8 : 8'h00);
            default: r = g + 8'd1;
        endcase
        return r;
    endfunction

    // Header byte k of the UDP header.
    function automatic logic [7:0] hdr_byte(input logic [2:0] k, input logic [15:0] cs);
        logic [7:0] r;
        case (k)
            3'd0:    r = SRC_PORT[15:8];
            3'd1:    r = SRC_PORT[7:0];
            3'd2:    r = DST_PORT[15:8];
            3'd3:    r = DST_PORT[7:0];
            3'd4:    r = LEN16[15:8];
            3'd5:    r = LEN16[7:0];
            3'd6:    r = cs[15:8];
            default: r = cs[7:0];
        endcase
        return r;
    endfunction

    // Payload byte for the current index: sequence mode overrides bytes 0..3.
    always_comb begin
        cur_byte = gen_q;
        if (mode_q == 2'd3 && idx < 11'd4) begin
            case (idx[1:0])
                2'd0:    cur_byte = cnt_q[31:24];
                2'd1:    cur_byte = cnt_q[23:16];
                2'd2:    cur_byte = cnt_q[15:8];
                default: cur_byte = cnt_q[7:0];
            endcase
        end
    end

`ifdef UDP_CSUM_EN
    // Pseudo-header plus UDP header (csum=0) folded into one constant.
    localparam logic [31:0] CSUM_BASE =
        32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]) +
        32'h0000_0011 + 32'(LEN16) + 32'(SRC_PORT) + 32'(DST_PORT) + 32'(LEN16);

    logic [31:0] acc;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [15:0] csum_fin;

    // Carry fold, complement, and map 0 to FFFF.
    always_comb begin
        fold1    = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
        fold2    = fold1[15:0] + {15'd0, fold1[16]};
        csum_fin = ~fold2;
        if (csum_fin == 16'h0000) csum_fin = 16'hFFFF;
    end
`else
    assign csum_field = 16'h0000;
`endif

    // Packet FSM with registered start/data/done/pkt_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            per_cnt <= '0;
            idx     <= '0;
            mode_q  <= '0;
            seed_q  <= '0;
            cnt_q   <= '0;
            gen_q   <= '0;
            start   <= 1'b0;
            data    <= '0;
            pkt_cnt <= '0;
            done    <= 1'b0;
`ifdef UDP_CSUM_EN
            acc        <= '0;
            csum_field <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!enable) begin
                        per_cnt <= '0;
                    end else if (per_cnt == PER_LAST) begin
                        per_cnt <= '0;
                        state   <= S_WAIT;
                    end else begin
                        per_cnt <= per_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (!busy) begin
                        mode_q <= mode;
                        seed_q <= seed;
                        cnt_q  <= pkt_cnt;
                        gen_q  <= first_byte(mode, seed);
                        idx    <= '0;
`ifdef UDP_CSUM_EN
                        acc    <= CSUM_BASE;
                        state  <= S_CSUM;
`else
                        state  <= S_LAUNCH;
`endif
                    end
                end
`ifdef UDP_CSUM_EN
                S_CSUM: begin
                    if (idx == 11'(PAYLOAD_LEN)) begin
                        csum_field <= csum_fin;
                        gen_q      <= first_byte(mode_q, seed_q);
                        idx        <= '0;
                        state      <= S_LAUNCH;
                    end else begin
                        acc   <= acc + (idx[0] ? {24'd0, cur_byte} : {16'd0, cur_byte, 8'd0});
                        gen_q <= next_gen(mode_q, gen_q);
                        idx   <= idx + 11'd1;
                    end
                end
`endif
                S_LAUNCH: begin
                    start <= 1'b1;
                    idx   <= '0;
                    state <= S_HDR;
                end
                S_HDR: begin
                    data <= hdr_byte(idx[2:0], csum_field);
                    if (idx == 11'd7) begin
                        idx   <= '0;
                        state <= S_PAY;
                    end else begin
                        idx <= idx + 11'd1;
                    end
                end
                S_PAY: begin
                    data  <= cur_byte;
                    gen_q <= next_gen(mode_q, gen_q);
                    if (idx == PAY_LAST) begin
                        state <= S_END;
                    end else begin
                        idx <= idx + 11'd1;
                    end
                end
                S_END: begin
                    start   <= 1'b0;
                    done    <= 1'b1;
                    pkt_cnt <= pkt_cnt + 32'd1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
